// File: rtl/calc_pkg.sv
// Shared constants for the calculator front end:
// key codes, opcodes, scanner states and the decoded key event bundle.
package calc_pkg;

  localparam int NUM_ROWS = 5;
  localparam int NUM_COLS = 4;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  // keycode = 4*row + col
  localparam logic [4:0] KC_1    = 5'd0;
  localparam logic [4:0] KC_2    = 5'd1;
  localparam logic [4:0] KC_3    = 5'd2;
  localparam logic [4:0] KC_ADD  = 5'd3;
  localparam logic [4:0] KC_4    = 5'd4;
  localparam logic [4:0] KC_5    = 5'd5;
  localparam logic [4:0] KC_6    = 5'd6;
  localparam logic [4:0] KC_SUB  = 5'd7;
  localparam logic [4:0] KC_7    = 5'd8;
  localparam logic [4:0] KC_8    = 5'd9;
  localparam logic [4:0] KC_9    = 5'd10;
  localparam logic [4:0] KC_MUL  = 5'd11;
  localparam logic [4:0] KC_CLR  = 5'd12;
  localparam logic [4:0] KC_0    = 5'd13;
  localparam logic [4:0] KC_EQ   = 5'd14;
  localparam logic [4:0] KC_DIV  = 5'd15;
  localparam logic [4:0] KC_BKSP = 5'd16;
  localparam logic [4:0] KC_MS   = 5'd17;
  localparam logic [4:0] KC_MR   = 5'd18;
  localparam logic [4:0] KC_MC   = 5'd19;

  localparam int PS_DIG  = 0;
  localparam int PS_OP   = 1;
  localparam int PS_EX   = 2;
  localparam int PS_CLR  = 3;
  localparam int PS_BKSP = 4;
  localparam int PS_MS   = 5;
  localparam int PS_MR   = 6;
  localparam int PS_MC   = 7;

  localparam logic [7:0] SEL_DIG  = 8'h01;
  localparam logic [7:0] SEL_OP   = 8'h02;
  localparam logic [7:0] SEL_EX   = 8'h04;
  localparam logic [7:0] SEL_CLR  = 8'h08;
  localparam logic [7:0] SEL_BKSP = 8'h10;
  localparam logic [7:0] SEL_MS   = 8'h20;
  localparam logic [7:0] SEL_MR   = 8'h40;
  localparam logic [7:0] SEL_MC   = 8'h80;

  typedef enum logic [2:0] {
    SCAN,
    PRESS_DB,
    EMIT,
    HOLD,
    REL_DB
  } scan_state_e;

  typedef struct packed {
    logic [7:0] sel;
    logic [3:0] digit;
    logic [1:0] opcode;
  } key_evt_t;

  function automatic logic [1:0] first_low(input logic [3:0] c);
    if (!c[0])      first_low = 2'd0;
    else if (!c[1]) first_low = 2'd1;
    else if (!c[2]) first_low = 2'd2;
    else            first_low = 2'd3;
  endfunction

endpackage

// File: rtl/key_decode.sv
// Keycode to key event: one-hot pulse select plus digit/opcode payload.
// Purely combinational; the scanner registers the result.
module key_decode
  import calc_pkg::*;
(
  input  logic [4:0] keycode_i,
  output key_evt_t   evt_o
);

  always_comb begin
    evt_o = '0;
    case (keycode_i)
      KC_1:    evt_o = {SEL_DIG, 4'd1, 2'd0};
      KC_2:    evt_o = {SEL_DIG, 4'd2, 2'd0};
      KC_3:    evt_o = {SEL_DIG, 4'd3, 2'd0};
      KC_ADD:  evt_o = {SEL_OP, 4'd0, OP_ADD};
      KC_4:    evt_o = {SEL_DIG, 4'd4, 2'd0};
      KC_5:    evt_o = {SEL_DIG, 4'd5, 2'd0};
      KC_6:    evt_o = {SEL_DIG, 4'd6, 2'd0};
      KC_SUB:  evt_o = {SEL_OP, 4'd0, OP_SUB};
      KC_7:    evt_o = {SEL_DIG, 4'd7, 2'd0};
      KC_8:    evt_o = {SEL_DIG, 4'd8, 2'd0};
      KC_9:    evt_o = {SEL_DIG, 4'd9, 2'd0};
      KC_MUL:  evt_o = {SEL_OP, 4'd0, OP_MUL};
      KC_CLR:  evt_o = {SEL_CLR, 4'd0, 2'd0};
      KC_0:    evt_o = {SEL_DIG, 4'd0, 2'd0};
      KC_EQ:   evt_o = {SEL_EX, 4'd0, 2'd0};
      KC_DIV:  evt_o = {SEL_OP, 4'd0, OP_DIV};
      KC_BKSP: evt_o = {SEL_BKSP, 4'd0, 2'd0};
      KC_MS:   evt_o = {SEL_MS, 4'd0, 2'd0};
      KC_MR:   evt_o = {SEL_MR, 4'd0, 2'd0};
      KC_MC:   evt_o = {SEL_MC, 4'd0, 2'd0};
      default: evt_o = '0;
    endcase
  end

endmodule

// File: rtl/keypad_scanner.sv
// 5x4 keypad scanner: row scan, press/release debounce,
// one registered single-cycle event pulse per accepted press.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_COLS-1:0] col_n,
  output logic [NUM_ROWS-1:0] row_n,
  output logic                dig_out,
  output logic [3:0]          digit,
  output logic                op_out,
  output logic [1:0]          opcode,
  output logic                ex_out,
  output logic                clr_out,
  output logic                bksp_out,
  output logic                ms_out,
  output logic                mr_out,
  output logic                mc_out
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DB_DONE    = BW'(DEBOUNCE_CYCLES);
  localparam logic [2:0]    ROW_LAST   = 3'(NUM_ROWS - 1);

  scan_state_e state_q, state_d;
  logic [2:0]    row_q, row_d;
  logic [1:0]    col_q, col_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [3:0]    col_m_q, col_s_q;
  key_evt_t      evt_q, evt_d, dec;

  logic          all_hi, key_lo;
  logic [BW-1:0] cnt_inc;
  logic [2:0]    row_nxt;

  key_decode u_dec (
    .keycode_i ({row_q, col_q}),
    .evt_o     (dec)
  );

  assign all_hi  = &col_s_q;
  assign key_lo  = ~col_s_q[col_q];
  assign cnt_inc = (cnt_q == DB_DONE) ? cnt_q : cnt_q + 1'b1;
  assign row_nxt = (row_q == ROW_LAST) ? 3'd0 : row_q + 3'd1;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SCAN: begin
        if (dwell_q != DWELL_LAST) begin
          dwell_d = dwell_q + 1'b1;
        end else begin
          dwell_d = '0;
          if (all_hi) begin
            row_d = row_nxt;
          end else begin
            col_d   = first_low(col_s_q);
            cnt_d   = '0;
            state_d = PRESS_DB;
          end
        end
      end
      PRESS_DB: begin
        if (key_lo) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DB_DONE) state_d = EMIT;
        end else begin
          cnt_d   = '0;
          dwell_d = '0;
          state_d = SCAN;
        end
      end
      EMIT: begin
        cnt_d   = '0;
        state_d = HOLD;
      end
      HOLD: begin
        cnt_d = '0;
        if (all_hi) state_d = REL_DB;
      end
      REL_DB: begin
        if (!all_hi) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else if (cnt_inc == DB_DONE) begin
          cnt_d   = '0;
          dwell_d = '0;
          row_d   = row_nxt;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // Event flops load only on the edge that enters EMIT.
  assign evt_d = (state_d == EMIT) ? dec : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SCAN;
      row_q   <= '0;
      col_q   <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      col_m_q <= '1;
      col_s_q <= '1;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      col_m_q <= col_n;
      col_s_q <= col_m_q;
      evt_q   <= evt_d;
    end
  end

  assign row_n    = ~(5'b00001 << row_q);
  assign dig_out  = evt_q.sel[PS_DIG];
  assign op_out   = evt_q.sel[PS_OP];
  assign ex_out   = evt_q.sel[PS_EX];
  assign clr_out  = evt_q.sel[PS_CLR];
  assign bksp_out = evt_q.sel[PS_BKSP];
  assign ms_out   = evt_q.sel[PS_MS];
  assign mr_out   = evt_q.sel[PS_MR];
  assign mc_out   = evt_q.sel[PS_MC];
  assign digit    = evt_q.digit;
  assign opcode   = evt_q.opcode;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 5-row x 4-column calculator keypad, debounces key presses and emits one single-cycle pulse per press. It drives the key-event inputs of the calculator control FSM: digit, operator, equals, clear, backspace and MS/MR/MC. It sits directly upstream of the control block; its outputs connect one-to-one to the control FSM inputs.

Parameters:
SCAN_DIV, 1000, clock cycles each row is driven before its columns are sampled (covers settle and synchroniser delay); minimum 4.
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a press or a release; minimum 2.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
col_n  in  4  keypad columns, active-low (pull-ups), asynchronous
row_n  out 4+1=5  row drive, active-low one-hot; exactly one bit low
dig_out  out  1  one-cycle pulse: digit key accepted
digit  out  4  digit value 0-9, valid while dig_out=1, otherwise 0
op_out  out  1  one-cycle pulse: operator key accepted
opcode  out  2  ADD=0 SUB=1 MUL=2 DIV=3, valid while op_out=1, otherwise 0
ex_out  out  1  one-cycle pulse: '=' key
clr_out  out  1  one-cycle pulse: 'C' key
bksp_out  out  1  one-cycle pulse: backspace
ms_out, mr_out, mc_out  out  1 each  one-cycle pulses: memory store / recall / clear

Behaviour:
- col_n passes through a 2-flop synchroniser; all decisions use the synchronised value col_s.
- Key map, row r / col c, keycode = 4r+c:
  - r0: 1 2 3 +
  - r1: 4 5 6 -
  - r2: 7 8 9 *
  - r3: C 0 = /
  - r4: BKSP MS MR MC
- Reset: state SCAN, row 0 driven (row_n=5'b11110), dwell and debounce counters 0, all pulse outputs 0, digit/opcode 0. Reset mid-debounce or mid-hold abandons the key; no pulse is emitted.
- SCAN:
  - Drive the current row for SCAN_DIV cycles, then sample col_s on the last dwell cycle.
  - All columns high: advance to the next row; row 4 wraps to row 0.
  - Any column low: latch the lowest low column index and go to PRESS_DB; the row is held.
- PRESS_DB:
  - The counter increments each cycle the latched column stays low.
  - Latched column high for any cycle: return to SCAN on the same row with a fresh dwell; no pulse.
  - Counter reaches DEBOUNCE_CYCLES: go to EMIT.
- EMIT: exactly one cycle. Assert the decoded pulse plus digit/opcode, then go to HOLD.
- HOLD:
  - Wait until all four columns are high, then go to REL_DB.
  - No further pulses for this press, including auto-repeat and second keys in the same row.
- REL_DB:
  - All columns high for DEBOUNCE_CYCLES consecutive cycles: go to SCAN and advance to the next row.
  - Any low column returns the block to HOLD with the counter cleared.
- Simultaneous keys:
  - Same row: lowest column wins.
  - Different rows: the first row scanned wins.
  - Other keys are ignored until a full release.
- Latency: from col_n stable low to the pulse is at most 2 sync + 5*SCAN_DIV + DEBOUNCE_CYCLES + 1 cycles.
- At most one pulse output is high in any cycle. Outputs are registered (the pulse comes from a flop in the EMIT state).
- Counter widths come from $clog2 of their parameter; counters saturate and never wrap.

Decomposition:
- Shared package calc_pkg:
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV
  - keycode constants for all 20 keys
  - NUM_ROWS=5, NUM_COLS=4
  - scanner state enum (SCAN, PRESS_DB, EMIT, HOLD, REL_DB)
- Sub-module key_decode: combinational mapping from keycode[4:0] to the pulse-select one-hot plus digit/opcode. The scanner registers its outputs.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
1. Hold key '7' (r2,c0) low for 40 cycles, then release → exactly one dig_out pulse with digit=7. Scanning resumes at row 3 after the release debounce.
2. Bounce '+' (r0,c3): low 3 cycles, high 1, low 3, then stable low 12 → one op_out with opcode=0; the pulse occurs only after 8 stable cycles; no earlier pulse.
3. Press '5' and '6' together (r1,c1 and c2) → single dig_out with digit=5. Keep '6' held after releasing '5' → no second pulse until all columns are high for 8 cycles.
4. Press MS, release, then press MR → ms_out pulse then mr_out pulse. Each lasts 1 cycle, and no other output pulses.
5. Assert reset during PRESS_DB for '=' (r3,c2) → ex_out never pulses; row_n=5'b11110 on the cycle after reset; all outputs 0.
6. No keys pressed for 100 cycles → row_n cycles 11110→11101→11011→10111→01111→11110, each row held 4 cycles; no pulses.
